// File: rtl/alu_accumulator.sv
// Accumulating stage behind the 8-bit lab ALU: registers each result, feeds the
// low nibble back as operand B, and runs a 4-step shift-add multiply for func 7.
//
// state | meaning
// IDLE  | ready for a request; single-cycle ops complete here
// MUL   | shift-add multiply in progress, requests refused
module alu_accumulator #(
  parameter int MUL_STEPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a_in,
  input  logic [2:0] func,
  output logic [7:0] result,
  output logic [3:0] b_fb,
  output logic       out_valid
);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  localparam logic [1:0] CNT_LAST = 2'(MUL_STEPS - 1);

  state_t     state_q, state_d;
  logic [3:0] a_q, b_q;
  logic [7:0] pp_q;
  logic [1:0] cnt_q;

  logic       accept;
  logic       mul_last;
  logic [3:0] b_cur;
  logic [4:0] rc_sum;
  logic       rc_carry;
  logic [7:0] alu_out;
  logic [7:0] step_add;
  logic [7:0] pp_next;

  assign b_cur    = result[3:0];
  assign b_fb     = result[3:0];
  assign accept   = in_valid & in_ready;
  assign mul_last = (state_q == MUL) && (cnt_q == CNT_LAST);

  // 4-bit ripple-carry chain; func 2 uses '+' and must match it bit for bit
  always_comb begin
    rc_sum   = 5'b0;
    rc_carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rc_sum[i] = a_in[i] ^ b_cur[i] ^ rc_carry;
      rc_carry  = (a_in[i] & b_cur[i]) | (rc_carry & (a_in[i] ^ b_cur[i]));
    end
    rc_sum[4] = rc_carry;
  end

  always_comb begin
    alu_out = 8'h00;
    unique case (func)
      3'd0: alu_out = {3'b0, 5'(a_in) + 5'd1};
      3'd1: alu_out = {3'b0, rc_sum};
      3'd2: alu_out = {3'b0, 5'(a_in) + 5'(b_cur)};
      3'd3: alu_out = {a_in | b_cur, a_in ^ b_cur};
      3'd4: alu_out = {7'b0, |{a_in, b_cur}};
      3'd5: alu_out = {a_in, b_cur};
      3'd6: alu_out = a_in[3] ? 8'h00 : ({4'b0, b_cur} << a_in[2:0]);
      default: alu_out = 8'h00;
    endcase
  end

  assign step_add = a_q[cnt_q] ? ({4'b0, b_q} << cnt_q) : 8'h00;
  assign pp_next  = pp_q + step_add;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && func == 3'd7) state_d = MUL;
      MUL:  if (mul_last)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= 8'h00;
      out_valid <= 1'b0;
      a_q       <= 4'h0;
      b_q       <= 4'h0;
      pp_q      <= 8'h00;
      cnt_q     <= 2'd0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        a_q   <= a_in;
        b_q   <= b_cur;
        pp_q  <= 8'h00;
        cnt_q <= 2'd0;
        if (func != 3'd7) begin
          result    <= alu_out;
          out_valid <= 1'b1;
        end
      end else if (state_q == MUL) begin
        pp_q  <= pp_next;
        cnt_q <= cnt_q + 2'd1;
        if (mul_last) begin
          result    <= pp_next;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
